// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    // Arbiter FSM encoding; values are fixed so they read the same in any waveform viewer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Byte width used by producers and the transmitter unless overridden.
    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    // Walk forward from the slot after i_last and stop at the first active request.
    always_comb begin
        o_grant = '0;
        o_index = i_last;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((int'(i_last) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_index        = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N byte producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = DEFAULT_W,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic [W-1:0]         tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 err_timeout
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    tx_state_t     r_state;
    tx_state_t     w_nextState;
    logic [W-1:0]  r_txData;
    logic [IW-1:0] r_grantId;
    logic          r_txStart;
    logic [CW-1:0] r_busyCnt;
    logic          r_errTimeout;

    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_pickIdx;
    logic          w_any;
    logic          w_handshake;
    logic [W-1:0]  w_reqBytes [N];

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req   (req_valid),
        .i_last  (r_grantId),
        .o_grant (w_grant),
        .o_index (w_pickIdx),
        .o_any   (w_any)
    );

    // A grant only happens in IDLE while the transmitter is quiet, so a frame still draining after reset is never overrun.
    assign w_handshake = (r_state == IDLE) && w_any && !tx_busy;

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_reqBytes[i] = req_data[i*W +: W];
        end
    end

    // State register; reset drops straight back to IDLE without touching the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant, pulse start, wait for busy to rise (bounded), then wait for it to fall.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_nextState = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_nextState = WAIT_DONE;
                end else if (r_busyCnt >= CNT_LAST) begin
                    w_nextState = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic: the one-hot ready is only ever driven during the IDLE handshake cycle.
    always_comb begin
        req_ready = '0;
        if (w_handshake) begin
            req_ready = w_grant;
        end
    end

    // Datapath: latch byte and index on handshake, one-cycle start pulse, busy-rise timer counted from the tx_start cycle, sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txData     <= '0;
            r_grantId    <= LAST_IDX;
            r_txStart    <= 1'b0;
            r_busyCnt    <= '0;
            r_errTimeout <= 1'b0;
        end else begin
            r_txStart <= w_handshake;
            if (w_handshake) begin
                r_txData  <= w_reqBytes[w_pickIdx];
                r_grantId <= w_pickIdx;
            end
            if (r_state == START) begin
                r_busyCnt <= CW'(1);
            end else if (r_state == WAIT_BUSY) begin
                r_busyCnt <= r_busyCnt + CW'(1);
            end
            if ((r_state == WAIT_BUSY) && !tx_busy && (r_busyCnt >= CNT_LAST)) begin
                r_errTimeout <= 1'b1;
            end
        end
    end

    assign tx_data     = r_txData;
    assign tx_start    = r_txStart;
    assign grant_id    = r_grantId;
    assign err_timeout = r_errTimeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_uart_tx_arbiter;

    localparam int N            = 4;
    localparam int W            = 8;
    localparam int IW           = 2;
    localparam int BUSY_TIMEOUT = 4;
    localparam int FRAME_LEN    = 10;

    typedef struct {
        logic [N-1:0] valid;
        logic         busy;
        logic [N-1:0] expReady;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } grant_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [IW-1:0]  grant_id;
    logic           err_timeout;

    logic [W-1:0] reqBytes [N];
    logic         forceBusy;
    logic         modelNormal;
    logic         modelBusy = 1'b0;
    int           modelCnt = 0;
    int           cyc = 0;

    int vectors = 0;
    int misses  = 0;

    grant_t       sbQ[$];
    int           grantLog[$];
    logic [W-1:0] startDataLog[$];
    int           modelLast = N - 1;
    int           hsCount = 0;
    int           prevHsCycle = 0;
    int           lastHsCycle = 0;
    int           startCount = 0;
    int           lastStartCycle = 0;
    logic         haveCur = 1'b0;
    logic [W-1:0] curData = '0;

    vec_t vecs [8];

    uart_tx_arbiter #(
        .N            (N),
        .W            (W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign tx_busy = forceBusy | modelBusy;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = reqBytes[i];
        end
    end

    // Ideal transmitter: busy rises the cycle after tx_start; tx_start cycle plus busy cycles span FRAME_LEN cycles.
    always @(posedge clk) begin
        if (modelNormal && tx_start) begin
            modelBusy <= 1'b1;
            modelCnt  <= FRAME_LEN - 1;
        end else if (modelCnt > 1) begin
            modelCnt <= modelCnt - 1;
        end else begin
            modelBusy <= 1'b0;
            modelCnt  <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic busy);
        req_valid = valid;
        forceBusy = busy;
    endtask

    function automatic int rrModel(input logic [N-1:0] v, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = v >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic monitorLoop();
        int     expIdx;
        int     obsIdx;
        grant_t g;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                modelLast = N - 1;
                sbQ.delete();
                haveCur = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    expIdx = rrModel(req_valid, modelLast);
                    obsIdx = -1;
                    for (int i = 0; i < N; i++) begin
                        if (req_ready[i] && obsIdx < 0) obsIdx = i;
                    end
                    checkOutput("req_ready", 32'(req_ready),
                                (tx_busy || sbQ.size() != 0 || expIdx < 0) ? 32'd0 : (32'd1 << expIdx));
                    if (expIdx >= 0) begin
                        g.idx  = expIdx;
                        g.data = reqBytes[IW'(expIdx)];
                        sbQ.push_back(g);
                        modelLast = expIdx;
                    end
                    grantLog.push_back(obsIdx);
                    prevHsCycle = lastHsCycle;
                    lastHsCycle = cyc;
                    hsCount++;
                end
                if (tx_start) begin
                    checkOutput("start_latency", 32'(cyc - lastHsCycle), 32'd1);
                    if (sbQ.size() == 0) begin
                        checkOutput("start_pending_grants", 32'd0, 32'd1);
                    end else begin
                        g = sbQ.pop_front();
                        checkOutput("tx_data", 32'(tx_data), 32'(g.data));
                        checkOutput("grant_id", 32'(grant_id), 32'(g.idx));
                        curData = g.data;
                        haveCur = 1'b1;
                    end
                    startDataLog.push_back(tx_data);
                    startCount++;
                    lastStartCycle = cyc;
                end
                if (tx_busy && haveCur) begin
                    checkOutput("tx_data_hold", 32'(tx_data), 32'(curData));
                end
            end
        end
    endtask

    task automatic doReset();
        int n = 0;
        while (modelBusy && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitHandshakes(input int target, input int budget, input string name);
        int n = 0;
        while (hsCount < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (hsCount < target) checkOutput(name, 32'(hsCount), 32'(target));
    endtask

    task automatic waitStarts(input int target, input int budget, input string name);
        int n = 0;
        while (startCount < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (startCount < target) checkOutput(name, 32'(startCount), 32'(target));
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((modelBusy || forceBusy || sbQ.size() != 0) && n < 60) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 60) checkOutput("idle_wait", 32'(sbQ.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int gbase;
        int sbase;
        int sCyc;
        int dropCyc;
        int n;
        int expOrder [6];
        logic [W-1:0] expData [6];
        int wrapOrder [3];

        vecs[0] = '{valid: 4'b0001, busy: 1'b0, expReady: 4'b0001};
        vecs[1] = '{valid: 4'b0110, busy: 1'b0, expReady: 4'b0010};
        vecs[2] = '{valid: 4'b1000, busy: 1'b0, expReady: 4'b1000};
        vecs[3] = '{valid: 4'b1010, busy: 1'b0, expReady: 4'b0010};
        vecs[4] = '{valid: 4'b1100, busy: 1'b0, expReady: 4'b0100};
        vecs[5] = '{valid: 4'b0000, busy: 1'b0, expReady: 4'b0000};
        vecs[6] = '{valid: 4'b1111, busy: 1'b0, expReady: 4'b0001};
        vecs[7] = '{valid: 4'b1111, busy: 1'b1, expReady: 4'b0000};
        expOrder  = '{0, 1, 2, 3, 0, 1};
        expData   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        wrapOrder = '{1, 3, 1};

        rst         = 1'b1;
        req_valid   = '0;
        forceBusy   = 1'b0;
        modelNormal = 1'b0;
        for (int i = 0; i < N; i++) reqBytes[i] = 8'(8'h20 + i);

        // reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'(N - 1));
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);

        // first-cycle arbitration from the reset state
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b1;
            applyStimulus('0, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            applyStimulus(vecs[i].valid, vecs[i].busy);
            #2;
            checkOutput("table_ready", 32'(req_ready), 32'(vecs[i].expReady));
        end
        @(negedge clk);
        applyStimulus('0, 1'b0);

        fork
            monitorLoop();
        join_none

        // single requester, 10-cycle frames
        modelNormal = 1'b1;
        doReset();
        reqBytes[0] = 8'h41;
        base = hsCount;
        req_valid = 4'b0001;
        waitHandshakes(base + 2, 40, "single_grants");
        checkOutput("single_spacing", 32'(lastHsCycle - prevHsCycle), 32'd12);
        @(negedge clk);
        req_valid = '0;
        waitIdle();

        // all four requesting continuously
        doReset();
        for (int i = 0; i < N; i++) reqBytes[i] = 8'(8'h10 + i);
        gbase = grantLog.size();
        sbase = startDataLog.size();
        base  = hsCount;
        req_valid = 4'b1111;
        waitHandshakes(base + 6, 6 * 13 + 20, "rr_grants");
        @(negedge clk);
        req_valid = '0;
        waitIdle();
        checkOutput("rr_grant_count", 32'(grantLog.size() - gbase), 32'd6);
        checkOutput("rr_start_count", 32'(startDataLog.size() - sbase), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (gbase + i < grantLog.size()) checkOutput("rr_order", 32'(grantLog[gbase + i]), 32'(expOrder[i]));
            if (sbase + i < startDataLog.size()) checkOutput("rr_tx_data_seq", 32'(startDataLog[sbase + i]), 32'(expData[i]));
        end

        // wrap-around between requesters 1 and 3
        doReset();
        reqBytes[1] = 8'h31;
        reqBytes[3] = 8'h33;
        gbase = grantLog.size();
        base  = hsCount;
        req_valid = 4'b0010;
        waitHandshakes(base + 1, 20, "wrap_first");
        @(negedge clk);
        req_valid = 4'b1010;
        waitHandshakes(base + 3, 40, "wrap_grants");
        @(negedge clk);
        req_valid = '0;
        waitIdle();
        checkOutput("wrap_count", 32'(grantLog.size() - gbase), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (gbase + i < grantLog.size()) checkOutput("wrap_order", 32'(grantLog[gbase + i]), 32'(wrapOrder[i]));
        end

        // transmitter busy across reset release
        forceBusy = 1'b1;
        doReset();
        reqBytes[0] = 8'h41;
        req_valid = 4'b0001;
        base = hsCount;
        #3;
        for (int i = 0; i < 5; i++) begin
            checkOutput("ready_while_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        forceBusy = 1'b0;
        dropCyc = cyc;
        #3;
        checkOutput("grant_after_busy", 32'(hsCount - base), 32'd1);
        checkOutput("grant_after_busy_cycle", 32'(lastHsCycle), 32'(dropCyc));
        @(negedge clk);
        req_valid = '0;
        waitIdle();

        // transmitter never raises busy
        doReset();
        modelNormal = 1'b0;
        reqBytes[0] = 8'h5A;
        reqBytes[1] = 8'hA5;
        gbase = grantLog.size();
        sbase = startCount;
        req_valid = 4'b0011;
        waitStarts(sbase + 1, 20, "timeout_start");
        sCyc = lastStartCycle;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #3;
            checkOutput("err_timing", 32'(err_timeout), 32'(cyc - sCyc >= 4));
        end
        checkOutput("regrant_cycle", 32'(lastHsCycle), 32'(sCyc + 4));
        checkOutput("regrant_count", 32'(grantLog.size() - gbase), 32'd2);
        if (grantLog.size() > gbase + 1) checkOutput("regrant_index", 32'(grantLog[gbase + 1]), 32'd1);
        @(negedge clk);
        req_valid   = '0;
        modelNormal = 1'b1;
        repeat (15) @(negedge clk);
        #3;
        checkOutput("err_sticky", 32'(err_timeout), 32'd1);
        waitIdle();

        // reset in WAIT_DONE with the error flag still set
        reqBytes[0] = 8'h55;
        base = hsCount;
        req_valid = 4'b0001;
        waitHandshakes(base + 1, 20, "midframe_grant");
        n = 0;
        while (!modelBusy && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #3;
        checkOutput("err_before_rst", 32'(err_timeout), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkOutput("midrst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("midrst_grant_id", 32'(grant_id), 32'(N - 1));
        checkOutput("midrst_err", 32'(err_timeout), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd0);
        base = hsCount;
        req_valid = 4'b0001;
        waitHandshakes(base + 1, 30, "post_rst_grant");
        @(negedge clk);
        req_valid = '0;
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
